// File: rtl/ext_mem_controller_if.sv
// CPU-side request/handshake bundle between the bus interface unit and the
// external-memory controller. The tristate data bus stays a plain module port.
interface ext_mem_controller_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  ext_cs;
  logic                  ext_we;
  logic                  ext_oe;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  ext_stall;
  logic                  ext_fault;

  modport master (
    output ext_cs, ext_we, ext_oe, bus_addr,
    input  ext_stall, ext_fault
  );

  modport slave (
    input  ext_cs, ext_we, ext_oe, bus_addr,
    output ext_stall, ext_fault
  );
endinterface

// File: rtl/ext_mem_controller.sv
// Async SRAM controller: turns a one-cycle chip-select request into a
// SETUP / STROBE(+wait states) / DONE sequence with registered strobes.
module ext_mem_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int EXT_ADDR_WIDTH = 11,
  parameter int EXT_SIZE       = 1200,
  parameter int WAIT_STATES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  ext_mem_controller_if.slave       bus,
  inout  wire  [DATA_WIDTH-1:0]     bus_data,
  output logic [EXT_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0]     sram_data,
  output logic                      sram_ce_n,
  output logic                      sram_we_n,
  output logic                      sram_oe_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] SIZE_LIMIT = ADDR_WIDTH'(EXT_SIZE);
  localparam logic [3:0]            WS_LOAD    = 4'(WAIT_STATES);

  state_t                      state, state_d;
  logic [3:0]                  cnt, cnt_d;
  logic [EXT_ADDR_WIDTH-1:0]   addr_d;
  logic                        we_q, we_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        fault_q, fault_d;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        wr_drive;
  logic                        fault_pulse;
  logic                        rd_drive;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = sram_addr;
    we_d    = we_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    case (state)
      IDLE: if (bus.ext_cs) begin
        addr_d  = bus.bus_addr[EXT_ADDR_WIDTH-1:0];
        we_d    = bus.ext_we;
        if (bus.ext_we) wdata_d = bus_data;
        fault_d = (bus.bus_addr >= SIZE_LIMIT);
        state_d = fault_d ? DONE : SETUP;
      end
      SETUP: begin
        cnt_d   = WS_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt != 4'd0) cnt_d = cnt - 4'd1;
        else             state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and drive enables are decoded from the next state and registered,
  // so they line up with the state they belong to and cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sram_addr   <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      rdata       <= '0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      wr_drive    <= 1'b0;
      fault_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      sram_addr   <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      sram_ce_n   <= !(state_d == SETUP || state_d == STROBE);
      sram_we_n   <= !(state_d == STROBE && we_d);
      sram_oe_n   <= !(state_d == STROBE && !we_d);
      wr_drive    <= we_d && !fault_d && (state_d != IDLE);
      fault_pulse <= (state_d == DONE) && fault_d;
      if (state == STROBE && cnt == 4'd0 && !we_q) rdata <= sram_data;
    end
  end

  assign rd_drive      = (state == DONE) && !we_q && bus.ext_cs && bus.ext_oe;
  assign bus_data      = rd_drive ? (fault_q ? {DATA_WIDTH{1'b1}} : rdata) : {DATA_WIDTH{1'bz}};
  assign sram_data     = wr_drive ? wdata_q : {DATA_WIDTH{1'bz}};
  assign bus.ext_stall = bus.ext_cs && (state != DONE);
  assign bus.ext_fault = fault_pulse;

endmodule

// File: tb/tb_ext_mem_controller.sv
// Directed plus random accesses against a behavioural SRAM and a per-access
// timing/data model derived from the access rules (wait states, size, fault).
module tb_ext_mem_controller;
  localparam int WS   = 2;
  localparam int SIZE = 1200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  ext_mem_controller_if #(.ADDR_WIDTH(16)) bif ();
  tri0  [7:0]  bus_data;
  tri0  [7:0]  sram_data;
  logic [10:0] sram_addr;
  logic        sram_ce_n, sram_we_n, sram_oe_n;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_wd  = 8'h00;
  logic [7:0] mem     [2048];
  logic [7:0] ref_mem [2048];

  ext_mem_controller #(.WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .bus_data  (bus_data),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural async SRAM
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'bz;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;
  assign bus_data = tb_drv ? tb_wd : 8'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  int r_stall, r_ce, r_we, r_oe, r_fault, r_sd, r_early, r_abad, r_done_cyc, r_ce_first;
  logic [7:0] r_data;
  bit r_timeout;

  // Caller is positioned just after a rising edge; returns just after a rising edge.
  task automatic access(input bit we, input logic [15:0] a, input logic [7:0] wd, input bit scr);
    bit done = 0;
    bit flt = (a >= 16'(SIZE));
    bif.ext_cs = 1'b1; bif.ext_we = we; bif.ext_oe = !we; bif.bus_addr = a;
    tb_drv = we; tb_wd = wd;
    r_stall = 0; r_ce = 0; r_we = 0; r_oe = 0; r_fault = 0; r_sd = 0;
    r_early = 0; r_abad = 0; r_ce_first = -1; r_done_cyc = -1; r_data = 8'h00;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!sram_ce_n) begin
        r_ce++;
        if (r_ce_first < 0) r_ce_first = cyc;
        if (sram_addr !== a[10:0]) r_abad++;
      end
      if (!sram_we_n) r_we++;
      if (!sram_oe_n) r_oe++;
      if (bif.ext_fault) r_fault++;
      if (we && sram_data === wd) r_sd++;
      if (bif.ext_stall) begin
        r_stall++;
        if (!we && bus_data !== 8'h00) r_early++;
      end else begin
        done = 1; r_data = bus_data; r_done_cyc = cyc;
      end
      // Request inputs change after the latching edge and must be ignored
      if (scr && k == 1) begin
        bif.bus_addr = 16'($urandom); tb_wd = 8'($urandom);
      end
    end
    r_timeout = !done;
    @(posedge clk); #1;
    bif.ext_cs = 1'b0; tb_drv = 1'b0;
    chk("timeout", 32'(r_timeout), 0);
    chk("stall_cycles", r_stall, flt ? 1 : 3 + WS);
    chk("ce_low_cycles", r_ce, flt ? 0 : 2 + WS);
    chk("we_low_cycles", r_we, (!flt && we) ? 1 + WS : 0);
    chk("oe_low_cycles", r_oe, (!flt && !we) ? 1 + WS : 0);
    chk("fault_pulses", r_fault, flt ? 1 : 0);
    chk("sram_addr", r_abad, 0);
    if (we) chk("sram_data_cycles", r_sd, flt ? 0 : 3 + WS);
    else begin
      chk("bus_early_drive", r_early, 0);
      chk("read_data", 32'(r_data), flt ? 32'hFF : 32'(ref_mem[a[10:0]]));
    end
    if (we && !flt) ref_mem[a[10:0]] = wd;
  endtask

  initial begin
    int d1, oe_cnt, drv_cnt, stall_cnt, ce_cnt;
    bit        rw;
    logic [15:0] ra;
    bif.ext_cs = 1'b0; bif.ext_we = 1'b0; bif.ext_oe = 1'b0; bif.bus_addr = '0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'($urandom_range(1, 255));
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'hA5; ref_mem[0] = 8'hA5;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_fault", bif.ext_fault, 0);
    chk("rst_sram_data_z", sram_data, 0);
    chk("rst_bus_data_z", bus_data, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: read offset 0
    access(0, 16'h000, 8'h00, 0);
    @(negedge clk); chk("t1_bus_z_after", bus_data, 0);
    @(posedge clk); #1;

    // 2: write last byte, then read back
    access(1, 16'h4AF, 8'h3C, 0);
    chk("t2_model_mem", mem[11'h4AF], 8'h3C);
    access(0, 16'h4AF, 8'h00, 0);

    // 3: first out-of-range offset, read and write
    access(0, 16'h4B0, 8'h00, 0);
    access(1, 16'h4B0, 8'h77, 0);
    @(negedge clk); chk("t3_fault_single", bif.ext_fault, 0);
    @(posedge clk); #1;

    // 4: back-to-back write then read of same location
    access(1, 16'h010, 8'h96, 0);
    d1 = r_done_cyc;
    access(0, 16'h010, 8'h00, 0);
    chk("t4_gap", r_ce_first - d1, 2);

    // 5: reset during STROBE of a write
    bif.ext_cs = 1'b1; bif.ext_we = 1'b1; bif.ext_oe = 1'b0; bif.bus_addr = 16'h300;
    tb_drv = 1'b1; tb_wd = 8'h5A;
    @(posedge clk); @(posedge clk);
    @(negedge clk); chk("t5_in_strobe", sram_we_n, 0);
    reset = 1'b1; bif.ext_cs = 1'b0; tb_drv = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t5_ce_n", sram_ce_n, 1);
    chk("t5_we_n", sram_we_n, 1);
    chk("t5_oe_n", sram_oe_n, 1);
    chk("t5_sram_z", sram_data, 0);
    chk("t5_bus_z", bus_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    access(0, 16'h010, 8'h00, 0);

    // 6: drop ext_cs during STROBE of a read
    bif.ext_cs = 1'b1; bif.ext_we = 1'b0; bif.ext_oe = 1'b1; bif.bus_addr = 16'h020;
    oe_cnt = 0; drv_cnt = 0; stall_cnt = 0; ce_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_ce_n) ce_cnt++;
    end
    @(posedge clk); #1 bif.ext_cs = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_ce_n) ce_cnt++;
      if (bus_data !== 8'h00) drv_cnt++;
      if (bif.ext_stall) stall_cnt++;
    end
    chk("t6_oe_cycles", oe_cnt, WS + 1);
    chk("t6_ce_cycles", ce_cnt, WS + 2);
    chk("t6_bus_z", drv_cnt, 0);
    chk("t6_stall", stall_cnt, 0);
    @(posedge clk); #1;

    // Random traffic with random gaps, some back-to-back, some faulting
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom);
      ra = 16'($urandom_range(0, 1299));
      if ($urandom_range(0, 7) == 0) ra = 16'hF000 | 16'($urandom);
      access(rw, ra, 8'($urandom_range(1, 255)), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
